// File: rtl/arbiter4_rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// requester count and the default hold limit.
package arbiter4_rr_pkg;

  localparam int NUM_REQ          = 4;
  localparam int MAX_HOLD_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage : arbiter4_rr_pkg

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: finds the first requester at or after
// last_id+1 (wrapping 3 -> 0) and reports it one-hot and as an index.
module rr_pick4
  import arbiter4_rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_id,
  output logic [NUM_REQ-1:0] winner,
  output logic [1:0]         winner_id,
  output logic               any
);

  // Candidate index and its request bit, in search order (position 0 is
  // the requester right after the previous holder).
  logic [1:0] cand_id  [NUM_REQ];
  logic       cand_req [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign cand_id[gi]  = last_id + 2'(gi + 1);
    assign cand_req[gi] = req[cand_id[gi]];
  end

  // Lowest search position with a pending request wins.
  always_comb begin
    winner_id = 2'd0;
    any       = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner_id = cand_id[k];
        any       = 1'b1;
      end
    end
    winner = any ? (4'b0001 << winner_id) : 4'b0000;
  end

endmodule : rr_pick4

// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with a bounded hold time. A grant is
// held until done, until the holder drops its request, or until MAX_HOLD
// cycles have elapsed; every release is followed by one idle cycle.
module arbiter4_rr
  import arbiter4_rr_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                done,
  output logic [NUM_REQ-1:0]  grant,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                timeout
);

  // Wide enough for MAX_HOLD-1 over the whole legal range 2..255.
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]         last_id_q, last_id_d;

  logic [NUM_REQ-1:0] pick_winner;
  logic [1:0]         pick_id;
  logic               pick_any;

  rr_pick4 u_pick (
    .req       (req),
    .last_id   (last_id_q),
    .winner    (pick_winner),
    .winner_id (pick_id),
    .any       (pick_any)
  );

  logic rel_done, rel_drop, rel_expire;

  // Next-state and output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    rel_done   = done;
    rel_drop   = ~req[grant_id_q];
    rel_expire = (hold_cnt_q == HOLD_LAST);

    unique case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (pick_any) begin
          state_d    = ST_GRANT;
          grant_d    = pick_winner;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_drop || rel_expire) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = 2'd0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          last_id_d  = grant_id_q;
          // Flag only a pure expiry; a coinciding done or drop is a normal release.
          timeout_d  = rel_expire && !rel_done && !rel_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything and points last_id at 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_id_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule : arbiter4_rr

// File: tb/tb_arbiter4_rr.sv
// Bench for arbiter4_rr: directed scenarios followed by random traffic,
// every cycle compared against a holder/cycle-count reference model.
module tb_arbiter4_rr;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  arbiter4_rr #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who holds the grant (-1 = nobody), how many grant
  // cycles the holder has had, who held last, and the expected timeout.
  int m_holder;
  int m_held;
  int m_last;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_held   = 0;
    m_last   = 3;
    m_to     = 1'b0;
  endtask

  // One rising edge of the model with the inputs present during that cycle.
  task automatic model_step(input logic [3:0] r, input logic d);
    if (m_holder < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (r[idx] && m_holder < 0) begin
          m_holder = idx;
          m_held   = 1;
        end
      end
    end else begin
      bit expired;
      expired = (m_held == MAX_HOLD);
      if (d || !r[m_holder] || expired) begin
        m_to     = expired && !d && r[m_holder];
        m_last   = m_holder;
        m_holder = -1;
        m_held   = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_cycle();
    logic [3:0] exp_grant;
    logic [1:0] id_from_grant;
    exp_grant = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
    check("grant",    32'(grant),    32'(exp_grant));
    check("grant_id", 32'(grant_id), (m_holder >= 0) ? 32'(m_holder) : 32'd0);
    check("busy",     32'(busy),     32'(m_holder >= 0));
    check("timeout",  32'(timeout),  32'(m_to));
    id_from_grant = 2'd0;
    for (int i = 0; i < 4; i++) if (grant[i]) id_from_grant = 2'(i);
    check("onehot0",  32'($onehot0(grant)), 32'd1);
    check("id_match", 32'(grant_id), 32'(id_from_grant));
  endtask

  // Called at a falling edge: drive inputs, step the model on the rising
  // edge, then compare at the next falling edge.
  task automatic cycle(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    cyc++;
    check_cycle();
    $display("cyc %0d req=%b done=%b grant=%b id=%0d busy=%b to=%b",
             cyc, r, d, grant, grant_id, busy, timeout);
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_cycle();
    check("rst_grant", 32'(grant), 32'd0);
    rst_n = 1'b1;

    // All requesting, never done: five full-length rotating grants.
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        cycle(4'b1111, 1'b0);
        check("rot_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
        check("rot_to", 32'(timeout), 32'd0);
      end
      cycle(4'b1111, 1'b0);
      check("rot_idle", 32'(grant), 32'd0);
      check("rot_timeout", 32'(timeout), 32'd1);
    end
    cycle(4'b0000, 1'b0);

    // Single requester released by done.
    cycle(4'b0100, 1'b0);
    check("done_grant", 32'(grant), 32'h4);
    check("done_id", 32'(grant_id), 32'd2);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    check("done_rel", 32'(grant), 32'd0);
    check("done_to", 32'(timeout), 32'd0);
    cycle(4'b0000, 1'b0);

    // Force last_id = 3, then 1010 grants 0010 then 1000.
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b1);
    cycle(4'b1010, 1'b0);
    check("rr_first", 32'(grant), 32'h2);
    cycle(4'b1010, 1'b1);
    check("rr_gap", 32'(grant), 32'd0);
    cycle(4'b1010, 1'b0);
    check("rr_second", 32'(grant), 32'h8);
    cycle(4'b1010, 1'b1);
    cycle(4'b0000, 1'b0);

    // Holder drops its request while others keep requesting.
    cycle(4'b1111, 1'b0);
    check("drop_hold", 32'(grant), 32'h1);
    cycle(4'b1110, 1'b0);
    check("drop_rel", 32'(grant), 32'd0);
    cycle(4'b1110, 1'b0);
    check("drop_next", 32'(grant), 32'h2);
    cycle(4'b1110, 1'b1);
    cycle(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    check("arst_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_id", 32'(grant_id), 32'd0);
    check("arst_to", 32'(timeout), 32'd0);
    model_reset();
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    cycle(4'b1000, 1'b0);
    check("arst_after", 32'(grant), 32'h8);
    cycle(4'b1000, 1'b1);

    // Random traffic, requests tend to persist so expiry is exercised.
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r, ($urandom_range(0, 11) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_arbiter4_rr

// File: doc/arbiter4_rr.md
ARBITER4_RR -- requirements
Module: arbiter4_rr

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of cycles one grant is held (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  input  4  request from requester 0..3, level-sensitive.
REQ-005 SHALL have port done  input  1  holder finished; releases the current grant.
REQ-006 SHALL have port grant  output  4  one-hot grant, registered.
REQ-007 SHALL have port grant_id  output  2  binary index of the asserted grant bit; 0 when no grant.
REQ-008 SHALL have port busy  output  1  high while any grant bit is high.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE with req != 0 at edge t, SHALL enter GRANT and assert exactly one grant bit from edge t (visible in cycle t+1); latency one cycle.
REQ-012 In IDLE with req == 0, SHALL stay in IDLE with grant = 0.
REQ-013 Winner SHALL be the first requesting index scanning last_id+1, last_id+2, ... modulo 4 (round-robin, wrap 3 -> 0).
REQ-014 last_id SHALL update to the winner's index on every release.
REQ-015 In GRANT, hold_cnt SHALL start at 0 on the first grant cycle and increment by 1 per cycle.
REQ-016 Release SHALL occur at the edge ending any GRANT cycle in which done = 1, or req[grant_id] = 0, or hold_cnt == MAX_HOLD-1.
REQ-017 On release, grant, grant_id and busy SHALL return to 0 in the following cycle and the FSM SHALL enter IDLE.
REQ-018 Every release SHALL be followed by at least one IDLE cycle with grant = 0 (no back-to-back grants, even with req still asserted).
REQ-019 timeout SHALL be 1 in the first IDLE cycle after a release caused only by hold_cnt expiry; 0 if done or req drop coincided with expiry.
REQ-020 grant SHALL never have more than one bit set.
REQ-021 Changes to non-granted req bits during GRANT SHALL not affect the current grant.
REQ-022 hold_cnt SHALL be sized to hold MAX_HOLD-1 without overflow.

Reset
REQ-023 While rst_n = 0: state = IDLE, grant = 0, grant_id = 0, busy = 0, timeout = 0, hold_cnt = 0, last_id = 3 (so requester 0 wins first).
REQ-024 Reset asserted mid-grant SHALL drop grant immediately (asynchronously), without a timeout pulse.
REQ-025 First arbitration SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-026 State encoding (IDLE, GRANT), requester count (4) and the MAX_HOLD default SHALL live in a shared package.
REQ-027 SHALL contain one sub-module, rr_pick4: combinational, inputs req[3:0] and last_id[1:0], outputs winner one-hot[3:0], winner_id[1:0] and any.
REQ-028 All outputs SHALL be driven directly from flops.

Verification
REQ-029 Reset release, req = 4'b1111 held, done = 0 -> grants rotate 0001, 0010, 0100, 1000, 0001, each 8 cycles long, each followed by one idle cycle and a timeout pulse.
REQ-030 req = 4'b0100 for 3 cycles then done = 1 for one cycle -> grant = 0100 and grant_id = 2 from cycle 2; grant = 0 the cycle after done; timeout stays 0.
REQ-031 last_id = 3, req = 4'b1010 -> grant = 0010; after its release with req unchanged -> grant = 1000.
REQ-032 During grant 0001, req[0] drops to 0 while req = 4'b1110 -> grant = 0 next cycle, then 0010 one cycle later.
REQ-033 rst_n pulsed low mid-grant -> grant, busy, grant_id = 0 without waiting for clk; after release with req = 4'b1000 -> grant 1000 one cycle later.
REQ-034 Across all scenarios, the bench SHALL check every cycle that grant is 0 or one-hot and that grant_id matches grant.
